sram_port_arbiter: RTL and testbench

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_port_arbiter_if.sv | 54 +++++
 rtl/sram_port_arbiter.sv | 90 +++++++++
 tb/tb_sram_port_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - DMA/pixel requester, SRAM and read-return signals of the SRAM port arbiter
interface sram_port_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 9,
  parameter int LW = 4
);
  logic          dma_req_i;
  logic          dma_wr_i;
  logic [AW-1:0] dma_addr_i;
  logic [LW-1:0] dma_len_i;
  logic [DW-1:0] dma_wdata_i;
  logic          dma_gnt_o;
  logic          dma_beat_o;
  logic          dma_done_o;

  logic          pix_req_i;
  logic [AW-1:0] pix_addr_i;
  logic [LW-1:0] pix_len_i;
  logic          pix_gnt_o;
  logic          pix_done_o;

  logic          sram_cs_n_o;
  logic          sram_wr_n_o;
  logic [AW-1:0] sram_addr_o;
  logic [DW-1:0] sram_wdata_o;
  logic [DW-1:0] sram_rdata_i;

  logic [DW-1:0] rdata_o;
  logic          rdata_vld_o;
  logic          rdata_own_o;
  logic          busy_o;

  // Arbiter side
  modport slave (
    input  dma_req_i, dma_wr_i, dma_addr_i, dma_len_i, dma_wdata_i,
    output dma_gnt_o, dma_beat_o, dma_done_o,
    input  pix_req_i, pix_addr_i, pix_len_i,
    output pix_gnt_o, pix_done_o,
    output sram_cs_n_o, sram_wr_n_o, sram_addr_o, sram_wdata_o,
    input  sram_rdata_i,
    output rdata_o, rdata_vld_o, rdata_own_o, busy_o
  );

  // Requester / SRAM side
  modport master (
    output dma_req_i, dma_wr_i, dma_addr_i, dma_len_i, dma_wdata_i,
    input  dma_gnt_o, dma_beat_o, dma_done_o,
    output pix_req_i, pix_addr_i, pix_len_i,
    input  pix_gnt_o, pix_done_o,
    input  sram_cs_n_o, sram_wr_n_o, sram_addr_o, sram_wdata_o,
    output sram_rdata_i,
    input  rdata_o, rdata_vld_o, rdata_own_o, busy_o
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - round-robin burst arbiter sharing one synchronous SRAM between DMA and pixel ports
module sram_port_arbiter #(
  parameter int DW = 32,
  parameter int AW = 9,
  parameter int LW = 4
) (
  input logic               clk,
  input logic               rst,
  sram_port_arbiter_if.slave bus
);
  typedef enum logic {IDLE, BURST} state_t;

  state_t        state_q, state_d;
  logic          own_q;       // 1 = pixel owns the current burst
  logic          wr_q;
  logic          gnt_q;
  logic          last_pix_q;  // last served requester was pixel
  logic          vld_q;
  logic          vld_own_q;
  logic [AW-1:0] addr_q;
  logic [LW-1:0] cnt_q;       // beats remaining after the current one
  logic          in_burst;
  logic          start;
  logic          pick_pix;
  logic          last_beat;

  assign in_burst  = (state_q == BURST);
  assign start     = (state_q == IDLE) && (bus.dma_req_i || bus.pix_req_i);
  assign pick_pix  = bus.pix_req_i && (!bus.dma_req_i || !last_pix_q);
  assign last_beat = in_burst && (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BURST;
      BURST:   if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_q      <= 1'b0;
      wr_q       <= 1'b0;
      gnt_q      <= 1'b0;
      last_pix_q <= 1'b1;
      vld_q      <= 1'b0;
      vld_own_q  <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      gnt_q     <= start;
      vld_q     <= in_burst && !wr_q;
      vld_own_q <= own_q;
      if (start) begin
        own_q      <= pick_pix;
        wr_q       <= !pick_pix && bus.dma_wr_i;
        addr_q     <= pick_pix ? bus.pix_addr_i : bus.dma_addr_i;
        cnt_q      <= pick_pix ? bus.pix_len_i : bus.dma_len_i;
        last_pix_q <= pick_pix;
      end else if (in_burst) begin
        // Address wraps naturally at 2^AW
        addr_q <= addr_q + AW'(1);
        cnt_q  <= cnt_q - LW'(1);
      end
    end
  end

  assign bus.sram_cs_n_o  = !in_burst;
  assign bus.sram_wr_n_o  = !(in_burst && wr_q);
  assign bus.sram_addr_o  = addr_q;
  assign bus.sram_wdata_o = (in_burst && wr_q) ? bus.dma_wdata_i : '0;

  assign bus.dma_gnt_o  = gnt_q && !own_q;
  assign bus.pix_gnt_o  = gnt_q && own_q;
  assign bus.dma_beat_o = in_burst && wr_q;
  assign bus.dma_done_o = last_beat && !own_q;
  assign bus.pix_done_o = last_beat && own_q;

  // SRAM read data arrives one cycle after its beat; pass it through only when valid
  assign bus.rdata_o     = vld_q ? bus.sram_rdata_i : '0;
  assign bus.rdata_vld_o = vld_q;
  assign bus.rdata_own_o = vld_q && vld_own_q;
  assign bus.busy_o      = in_burst;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   nvld;

  always #5 clk = ~clk;

  sram_port_arbiter_if #(.DW(DW), .AW(AW), .LW(LW)) bus ();

  sram_port_arbiter #(.DW(DW), .AW(AW), .LW(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {cs_n, wr_n, dma_gnt, dma_beat, dma_done, pix_gnt, pix_done, busy, rdata_vld, rdata_own}
  logic [9:0] fl;
  assign fl = {bus.sram_cs_n_o, bus.sram_wr_n_o, bus.dma_gnt_o, bus.dma_beat_o, bus.dma_done_o,
               bus.pix_gnt_o, bus.pix_done_o, bus.busy_o, bus.rdata_vld_o, bus.rdata_own_o};

  logic [DW-1:0] mem [0:(1<<AW)-1];

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {16'hC0DE, 7'h00, a};
  endfunction

  function automatic logic [DW-1:0] wword(input int k);
    return 32'h1234_5600 + DW'(k);
  endfunction

  // Synchronous SRAM: reads return a fixed address pattern one cycle later
  always @(posedge clk) begin
    if (!bus.sram_cs_n_o && !bus.sram_wr_n_o) mem[bus.sram_addr_o] <= bus.sram_wdata_o;
    bus.sram_rdata_i <= bus.sram_cs_n_o ? '0 : pat(bus.sram_addr_o);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst             = 1'b0;
    bus.dma_req_i   = 1'b0;
    bus.dma_wr_i    = 1'b0;
    bus.dma_addr_i  = '0;
    bus.dma_len_i   = '0;
    bus.dma_wdata_i = '0;
    bus.pix_req_i   = 1'b0;
    bus.pix_addr_i  = '0;
    bus.pix_len_i   = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_flags", fl, 10'b1100000000);
    chk("rst_addr", bus.sram_addr_o, 0);
    chk("rst_wdata", bus.sram_wdata_o, 0);
    chk("rst_rdata", bus.rdata_o, 0);
    repeat (2) step();
    rst = 1'b0;

    // DMA write 0x010, len 3
    bus.dma_req_i  = 1'b1;
    bus.dma_wr_i   = 1'b1;
    bus.dma_addr_i = 9'h010;
    bus.dma_len_i  = 4'd3;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 0) bus.dma_req_i = 1'b0;
      bus.dma_wdata_i = wword(k);
      #1;
      chk("wr_flags", fl, {1'b0, 1'b0, (k == 0), 1'b1, (k == 3), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      chk("wr_addr", bus.sram_addr_o, 64'(9'h010 + k));
      chk("wr_wdata", bus.sram_wdata_o, wword(k));
    end
    step(); #1;
    chk("wr_idle", fl, 10'b1100000000);
    for (int k = 0; k < 4; k++) chk("wr_mem", mem[9'h010 + k], wword(k));

    // Pixel read 0x1FE, len 3, wraps past 0x1FF
    bus.pix_req_i  = 1'b1;
    bus.pix_addr_i = 9'h1FE;
    bus.pix_len_i  = 4'd3;
    for (int k = 0; k < 5; k++) begin
      logic [AW-1:0] a;
      step();
      if (k == 0) bus.pix_req_i = 1'b0;
      #1;
      a = 9'h1FE + 9'(k);
      if (k < 4) begin
        chk("pix_flags", fl, {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, (k == 0), (k == 3), 1'b1, (k > 0), (k > 0)});
        chk("pix_addr", bus.sram_addr_o, a);
      end else begin
        chk("pix_tail", fl, 10'b1100000011);
      end
      if (k > 0) chk("pix_rdata", bus.rdata_o, pat(a - 9'd1));
    end
    step(); #1;
    chk("pix_idle", fl, 10'b1100000000);

    // Tie from reset: DMA, pixel, DMA, pixel with one idle cycle between
    rst            = 1'b1;
    bus.dma_req_i  = 1'b1;
    bus.dma_wr_i   = 1'b0;
    bus.dma_addr_i = 9'h020;
    bus.dma_len_i  = 4'd0;
    bus.pix_req_i  = 1'b1;
    bus.pix_addr_i = 9'h040;
    bus.pix_len_i  = 4'd0;
    step();
    rst = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      logic dg, pg;
      step(); #1;
      dg = (c == 1) || (c == 5);
      pg = (c == 3) || (c == 7);
      chk($sformatf("rr_c%0d", c), {bus.dma_gnt_o, bus.pix_gnt_o, bus.sram_cs_n_o}, {dg, pg, !(dg || pg)});
      if (dg) chk("rr_dma_addr", bus.sram_addr_o, 9'h020);
      if (pg) chk("rr_pix_addr", bus.sram_addr_o, 9'h040);
    end

    // DMA read len 15, req dropped after grant; pixel request arrives mid-burst and waits
    bus.dma_req_i  = 1'b1;
    bus.dma_wr_i   = 1'b0;
    bus.dma_addr_i = 9'h100;
    bus.dma_len_i  = 4'd15;
    bus.pix_req_i  = 1'b0;
    bus.pix_addr_i = 9'h0AA;
    bus.pix_len_i  = 4'd0;
    nvld = 0;
    for (int k = 0; k < 17; k++) begin
      step();
      if (k == 0) bus.dma_req_i = 1'b0;
      if (k == 5) bus.pix_req_i = 1'b1;
      #1;
      if (bus.rdata_vld_o && !bus.rdata_own_o) nvld++;
      if (k < 16) begin
        chk("dr_flags", fl, {1'b0, 1'b1, (k == 0), 1'b0, (k == 15), 1'b0, 1'b0, 1'b1, (k > 0), 1'b0});
        chk("dr_addr", bus.sram_addr_o, 64'(9'h100 + k));
      end else begin
        chk("dr_tail", fl, 10'b1100000010);
      end
      if (k > 0) chk("dr_rdata", bus.rdata_o, pat(9'(9'h100 + k - 1)));
    end
    chk("dr_vld_count", nvld, 16);
    step(); #1;
    bus.pix_req_i = 1'b0;
    chk("wait_pix_gnt", fl, 10'b0100011100);
    chk("wait_pix_addr", bus.sram_addr_o, 9'h0AA);
    step(); #1;
    chk("wait_pix_rdata_flags", fl, 10'b1100000011);
    chk("wait_pix_rdata", bus.rdata_o, pat(9'h0AA));

    // Reset at beat 2 of a len 7 pixel read
    bus.pix_req_i  = 1'b1;
    bus.pix_addr_i = 9'h080;
    bus.pix_len_i  = 4'd7;
    for (int k = 0; k < 3; k++) begin
      step();
      if (k == 0) bus.pix_req_i = 1'b0;
      #1;
      chk("pr_flags", fl, {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, (k == 0), 1'b0, 1'b1, (k > 0), (k > 0)});
      chk("pr_addr", bus.sram_addr_o, 64'(9'h080 + k));
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_flags", fl, 10'b1100000000);
    chk("mid_rst_addr", bus.sram_addr_o, 0);
    chk("mid_rst_rdata", bus.rdata_o, 0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step(); #1;
      chk("post_rst_idle", fl, 10'b1100000000);
    end
    bus.pix_req_i  = 1'b1;
    bus.pix_addr_i = 9'h033;
    bus.pix_len_i  = 4'd0;
    step();
    bus.pix_req_i = 1'b0;
    #1;
    chk("post_rst_gnt", fl, 10'b0100011100);
    chk("post_rst_addr", bus.sram_addr_o, 9'h033);
    step(); #1;
    chk("post_rst_rdata_flags", fl, 10'b1100000011);
    chk("post_rst_rdata", bus.rdata_o, pat(9'h033));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
